// File: rtl/stream_fifo_in.sv
// stream_fifo_in: first-word-fall-through input FIFO with valid/ready
// handshakes on both sides, occupancy count, almost_full flag and a
// clearable high-water mark.
//
// Handshake semantics (both ports):
//   A beat transfers on a rising clk edge where valid and ready are both 1.
//   s_ready and m_valid are decoded from the registered count only, so they
//   never depend combinationally on s_valid or m_ready. The producer holds
//   s_data stable while s_valid is high and the beat has not transferred.
module stream_fifo_in #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     hwm,
  input  logic                       hwm_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Full and almost-full thresholds sized to the count register.
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  // Storage; deliberately not reset, only pointers and count define content.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] hwm_q;
  logic [CNT_W-1:0] hwm_next;
  logic             push;
  logic             pop;

  // Port flags decoded from registered occupancy only.
  always_comb begin
    s_ready     = (count_q != DEPTH_C);
    m_valid     = (count_q != '0);
    almost_full = (count_q >= AF_C);
  end

  // Transfer qualifiers for each side.
  always_comb begin
    push = s_valid & s_ready;
    pop  = m_valid & m_ready;
  end

  // Next occupancy: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  // Next high-water mark: clear reloads the new occupancy, otherwise track max.
  always_comb begin
    hwm_next = hwm_q;
    if (hwm_clr) begin
      hwm_next = count_next;
    end else if (count_next > hwm_q) begin
      hwm_next = count_next;
    end
  end

  // Write port: store payload at the write pointer on each accepted beat.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointer, occupancy and high-water registers; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_next;
      hwm_q   <= hwm_next;
    end
  end

  // First-word-fall-through head and debug outputs.
  always_comb begin
    m_data = mem[rd_ptr];
    count  = count_q;
    hwm    = hwm_q;
  end

  // Occupancy never exceeds the storage size.
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count_q <= DEPTH_C);

  // High-water mark never trails the current occupancy.
  a_hwm_ge_count : assert property (@(posedge clk) disable iff (rst)
    hwm_q >= count_q);

endmodule

// File: tb/tb_stream_fifo_in.sv
// Bench for stream_fifo_in: directed vector table, random wrap-around
// section against a queue model, and an asynchronous reset sequence.
module tb_stream_fifo_in;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic [CNT_W-1:0]  hwm;
  logic              hwm_clr;

  int n_cmp = 0;
  int n_err = 0;

  stream_fifo_in #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .hwm(hwm), .hwm_clr(hwm_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              sv;
    logic [DATA_W-1:0] sd;
    logic              mr;
    logic              clr;
    logic [CNT_W-1:0]  e_count;
    logic              e_sready;
    logic              e_mvalid;
    logic [DATA_W-1:0] e_mdata;
    logic              e_af;
    logic [CNT_W-1:0]  e_hwm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic [DATA_W-1:0] sd,
                              input logic mr, input logic clr,
                              input int e_count, input logic [DATA_W-1:0] e_mdata,
                              input int e_hwm);
    vec_t v;
    v.sv       = sv;
    v.sd       = sd;
    v.mr       = mr;
    v.clr      = clr;
    v.e_count  = CNT_W'(e_count);
    v.e_sready = (e_count != DEPTH);
    v.e_mvalid = (e_count != 0);
    v.e_mdata  = e_mdata;
    v.e_af     = (e_count >= AF);
    v.e_hwm    = CNT_W'(e_hwm);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [CNT_W-1:0] e_count,
                               input logic e_sready, input logic e_mvalid,
                               input logic [DATA_W-1:0] e_mdata, input logic e_af,
                               input logic [CNT_W-1:0] e_hwm);
    check({tag, ".count"}, 32'(count), 32'(e_count));
    check({tag, ".s_ready"}, 32'(s_ready), 32'(e_sready));
    check({tag, ".m_valid"}, 32'(m_valid), 32'(e_mvalid));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(e_af));
    check({tag, ".hwm"}, 32'(hwm), 32'(e_hwm));
    if (e_mvalid) check({tag, ".m_data"}, 32'(m_data), 32'(e_mdata));
  endtask

  // Scoreboard for the random section
  logic [DATA_W-1:0] exp_q[$];

  initial begin
    int m_count;
    int m_hwm;
    logic held;
    logic do_push;
    logic do_pop;
    logic [DATA_W-1:0] head;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; hwm_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", '0, 1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: push A5 into empty FIFO, visible next cycle, drained after.
    vecs.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1, 8'hA5, 1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1));
    // Fill with 00..0F, head stays 00.
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk(1'b1, 8'(i), 1'b0, 1'b0, i + 1, 8'h00, (i + 1 > 1) ? i + 1 : 1));
    // Extra beat held while full.
    vecs.push_back(mk(1'b1, 8'h10, 1'b0, 1'b0, 16, 8'h00, 16));
    // Full with pop: 00 leaves, no push.
    vecs.push_back(mk(1'b1, 8'h10, 1'b1, 1'b0, 15, 8'h01, 16));
    // s_ready back: held 10 now accepted.
    vecs.push_back(mk(1'b1, 8'h10, 1'b0, 1'b0, 16, 8'h01, 16));
    // Drain 13 entries down to 3.
    for (int j = 1; j <= 13; j++)
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 16 - j, 8'(8'h01 + j), 16));
    // Clear high-water mark at count 3, then one push raises it to 4.
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3, 8'h0E, 3));
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 1'b0, 4, 8'h0E, 4));

    foreach (vecs[k]) begin
      @(negedge clk);
      s_valid = vecs[k].sv;
      s_data  = vecs[k].sd;
      m_ready = vecs[k].mr;
      hwm_clr = vecs[k].clr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", k), vecs[k].e_count, vecs[k].e_sready,
                    vecs[k].e_mvalid, vecs[k].e_mdata, vecs[k].e_af, vecs[k].e_hwm);
    end

    // Random wrap-around traffic against the queue model.
    exp_q = '{8'h0E, 8'h0F, 8'h10, 8'h20};
    m_count = 4;
    m_hwm = 4;
    held = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hwm_clr = 1'b0;
      if (!held) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom_range(0, 255));
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check_outputs($sformatf("rnd%0d", c), CNT_W'(m_count), m_count != DEPTH,
                    m_count != 0, head, m_count >= AF, CNT_W'(m_hwm));
      do_push = s_valid && (m_count != DEPTH);
      do_pop  = m_ready && (m_count != 0);
      @(posedge clk);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(s_data);
      m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      if (m_count > m_hwm) m_hwm = m_count;
      held = s_valid && !do_push;
    end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("rnd_final.count", 32'(count), 32'(m_count));

    // Asynchronous reset mid-burst, then first push after reset comes out first.
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", '0, 1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1; s_data = 8'h77;
    @(posedge clk);
    #1;
    check_outputs("post_rst", CNT_W'(1), 1'b1, 1'b1, 8'h77, 1'b0, CNT_W'(1));
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst_drain", '0, 1'b1, 1'b0, '0, 1'b0, CNT_W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
